npu_seq_engine: RTL and testbench
=================================

Name: npu_seq_engine

Overview:
Memory-mapped NPU slave that computes N parallel K_SIZE x K_SIZE signed dot products. Unlike the host-stepped PE wrapper, this block runs its own sequencer. The host loads weight and input bytes through an auto-incrementing pointer port, then writes START. The block performs all K*K MAC taps, requantises (shift, optional ReLU, saturate) and raises done. It sits behind axi2mem on the AXI crossbar like SRAM, and is generalised in N, K_SIZE, DATA_WIDTH and result packing.

Parameters:
N, 10, number of MAC lanes
K_SIZE, 3, kernel side; KK = K_SIZE*K_SIZE taps per lane
DATA_WIDTH, 8, signed operand/result width
AXI_WIDTH, 32, bus word width (BPW = AXI_WIDTH/DATA_WIDTH bytes-per-word)
ADDR_W, 5, word-index address width; must cover 4 + ceil(N/BPW) words
ACC_W, 2*DATA_WIDTH+$clog2(KK), derived accumulator width

Ports:
clk  in  1  clock
rst_n  in  1  reset: asynchronous, active-high (asserted when 1)
req_i  in  1  access qualifier
wen_i  in  4  byte enables; write when req_i & |wen_i, read when req_i & wen_i==0
addr_i  in  ADDR_W  word index
wdata_i  in  AXI_WIDTH  write data
rdata_o  out  AXI_WIDTH  registered read data, 1-cycle latency
busy_o  out  1  sequencer active
done_irq_o  out  1  sticky completion flag (level)

Behaviour:
- Reset: all outputs 0; buffer, accumulators, results, pointer, cfg and flags cleared. Reset mid-operation aborts the run and returns to IDLE.
- Map, word 0, CTRL (write): bit0 START, bit1 RELU_EN, bit2 BCAST, bit3 CLR_DONE, bits[12:8] SHIFT. Read returns cfg bits; START and CLR_DONE read as 0.
- Map, word 1, STATUS (read): bit0 busy, bit1 done, bit2 err. Write with bit2=1 clears err.
- Map, word 2, PTR: byte pointer into the buffer (write/read).
- Map, word 3, DATA: byte PTR+b <= wdata_i[8b+7:8b] for each b with wen_i[b]=1. PTR += BPW on every DATA write, whatever the byte enables.
- Map, words 4.., RES: word j = {res[BPW*j], ..., res[BPW*j+BPW-1]}, with the first result in the MSBs. Lanes >= N read 0. Unmapped addresses read 0.
- Buffer: (2N+1)*KK bytes. Lane weights at [i*KK]. Lane inputs at [(N+i)*KK]. Broadcast inputs at [2N*KK].
- Out-of-range bytes are dropped and set err.
- DATA or PTR writes while busy are ignored and set err. START while busy is ignored and sets err.
- rdata_o updates only on read accesses; it holds its value otherwise.
- FSM: IDLE -START-> CLEAR (1 cycle, acc=0, done=0) -> MAC (KK cycles, tap 0..KK-1: acc_i += w_i[tap]*x[tap], where x is lane i's inputs or the broadcast inputs when BCAST) -> POST (1 cycle) -> IDLE, done=1.
- busy_o is high in CLEAR, MAC and POST. With the START write in cycle t, busy_o rises at t+1 and done plus results are visible at t+KK+3.
- POST arithmetic: v = acc >>> SHIFT (arithmetic shift). If RELU_EN and v<0, v=0. Saturate v to [-2^(DW-1), 2^(DW-1)-1]. All multiplies are signed.
- Results hold until the next POST. CLR_DONE and START both clear done. If START and CLR_DONE arrive together, START wins.

Decomposition:
- Package npu_seq_pkg: fsm_state_t {IDLE, CLEAR, MAC, POST}; register word-index constants; CTRL bit positions; saturate/requant function.
- Sub-module npu_mac_lane: one lane's accumulator plus POST requantisation, instantiated N times via generate.

Test Plan:
- Reset released -> rdata_o=0, busy_o=0, done_irq_o=0; STATUS read = 0x0.
- Weights all 1, lane i inputs all i+1, SHIFT=0, START -> busy for KK+2=11 cycles, done at t+12; RES word0 = 0x09121B24, word2 = 0x515A0000.
- Lane0 w=127,x=127 SHIFT=12 -> 35 (0x23). w=-128,x=127 SHIFT=12 RELU off -> -36 (0xDC), RELU on -> 0. SHIFT=0 -> 127 and -128 saturated.
- BCAST=1, lane inputs 0, broadcast bytes all 2, lane i weights all i -> res[i]=18*i.
- PTR write then DATA write while busy -> err=1, buffer unchanged; START while busy ignored; DATA with wen_i=4'b0011 writes 2 bytes, PTR advances by 4.
- Reset asserted during MAC tap 4, then released and rerun -> busy_o=0 and results 0 immediately; rerun gives the correct values.

Source files
------------

// File: rtl/npu_seq_pkg.sv
// Shared types, register map and requantisation helper for the NPU sequencer engine.
package npu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        MAC   = 2'd2,
        POST  = 2'd3
    } fsm_state_t;

    localparam int REG_CTRL   = 0;
    localparam int REG_STATUS = 1;
    localparam int REG_PTR    = 2;
    localparam int REG_DATA   = 3;
    localparam int REG_RES    = 4;

    localparam int CTRL_START    = 0;
    localparam int CTRL_RELU     = 1;
    localparam int CTRL_BCAST    = 2;
    localparam int CTRL_CLR_DONE = 3;
    localparam int CTRL_SHIFT_LO = 8;
    localparam int SHIFT_W       = 5;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    localparam int PTR_W = 16;

    // Arithmetic shift, optional ReLU, then clamp to a signed dw-bit range.
    function automatic logic signed [63:0] requant(
        input logic signed [63:0]  acc,
        input logic [SHIFT_W-1:0]  shift,
        input logic                relu,
        input int                  dw
    );
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        v  = acc >>> shift;
        if (relu && (v < 64'sd0)) v = 64'sd0;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)      v = hi;
        else if (v < lo) v = lo;
        return v;
    endfunction

endpackage

// File: rtl/npu_mac_lane.sv
// One MAC lane: signed accumulator cleared/stepped by the sequencer, requantised result register.
module npu_mac_lane
    import npu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_W      = 20
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clear,
    input  logic                         i_mac,
    input  logic                         i_post,
    input  logic signed [DATA_WIDTH-1:0] i_w,
    input  logic signed [DATA_WIDTH-1:0] i_x,
    input  logic [SHIFT_W-1:0]           i_shift,
    input  logic                         i_relu,
    output logic signed [DATA_WIDTH-1:0] o_res
);

    logic signed [ACC_W-1:0]        r_acc;
    logic signed [DATA_WIDTH-1:0]   r_res;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [63:0]             w_q;
    logic                           w_unused_q;

    assign w_prod     = i_w * i_x;
    assign w_q        = requant(64'(r_acc), i_shift, i_relu, DATA_WIDTH);
    assign w_unused_q = ^w_q[63:DATA_WIDTH];
    assign o_res      = r_res;

    // NOTE: sequential state uses non-blocking assignments so all lanes see the same pre-edge values.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_acc <= '0;
            r_res <= '0;
        end else begin
            if (i_clear)    r_acc <= '0;
            else if (i_mac) r_acc <= r_acc + ACC_W'(w_prod);
            if (i_post)     r_res <= w_q[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/npu_seq_engine.sv
// Memory-mapped NPU slave: pointer-loaded operand buffer, self-sequenced N-lane KxK dot products.
module npu_seq_engine
    import npu_seq_pkg::*;
#(
    parameter int N          = 10,
    parameter int K_SIZE     = 3,
    parameter int DATA_WIDTH = 8,
    parameter int AXI_WIDTH  = 32,
    parameter int ADDR_W     = 5,
    parameter int ACC_W      = 2*DATA_WIDTH + $clog2(K_SIZE*K_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_i,
    input  logic [3:0]           wen_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [AXI_WIDTH-1:0] wdata_i,
    output logic [AXI_WIDTH-1:0] rdata_o,
    output logic                 busy_o,
    output logic                 done_irq_o
);

    localparam int KK        = K_SIZE * K_SIZE;
    localparam int BPW       = AXI_WIDTH / DATA_WIDTH;
    localparam int BUF_BYTES = (2*N + 1) * KK;
    localparam int BUF_AW    = $clog2(BUF_BYTES);
    localparam int TAP_W     = $clog2(KK + 1);
    localparam int X_BASE    = N * KK;
    localparam int B_BASE    = 2 * N * KK;

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(REG_CTRL);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(REG_STATUS);
    localparam logic [ADDR_W-1:0] A_PTR    = ADDR_W'(REG_PTR);
    localparam logic [ADDR_W-1:0] A_DATA   = ADDR_W'(REG_DATA);
    localparam logic [ADDR_W-1:0] A_RES    = ADDR_W'(REG_RES);

    fsm_state_t                   r_state, w_next;
    logic [TAP_W-1:0]             r_tap;
    logic [DATA_WIDTH-1:0]        r_buf [BUF_BYTES];
    logic [PTR_W-1:0]             r_ptr;
    logic                         r_relu, r_bcast, r_done, r_err;
    logic [SHIFT_W-1:0]           r_shift;
    logic [AXI_WIDTH-1:0]         r_rdata, w_rd;
    logic signed [DATA_WIDTH-1:0] w_res [N];

    logic             w_wr, w_rd_en, w_busy, w_ctrl_wr, w_ptr_wr, w_data_wr, w_stat_wr;
    logic             w_start, w_start_bad, w_err_set, w_clear, w_mac, w_post;
    logic [PTR_W:0]   w_bidx [BPW];
    logic [BPW-1:0]   w_bok;
    logic [ADDR_W-1:0] w_res_word;

    assign w_wr        = req_i & (|wen_i);
    assign w_rd_en     = req_i & ~(|wen_i);
    assign w_busy      = (r_state != IDLE);
    assign w_ctrl_wr   = w_wr && (addr_i == A_CTRL);
    assign w_stat_wr   = w_wr && (addr_i == A_STATUS);
    assign w_ptr_wr    = w_wr && (addr_i == A_PTR);
    assign w_data_wr   = w_wr && (addr_i == A_DATA);
    assign w_start     = w_ctrl_wr & wdata_i[CTRL_START] & ~w_busy;
    assign w_start_bad = w_ctrl_wr & wdata_i[CTRL_START] & w_busy;
    assign w_res_word  = addr_i - A_RES;

    always_comb begin
        w_bok = '0;
        for (int b = 0; b < BPW; b++) begin
            w_bidx[b] = {1'b0, r_ptr} + (PTR_W+1)'(b);
            w_bok[b]  = (w_bidx[b] < (PTR_W+1)'(BUF_BYTES));
        end
    end

    assign w_err_set = (w_busy & (w_ptr_wr | w_data_wr | w_start_bad))
                     | (w_data_wr & ~w_busy & (|(wen_i[BPW-1:0] & ~w_bok)));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= IDLE;
            r_tap   <= '0;
        end else begin
            r_state <= w_next;
            r_tap   <= (r_state == MAC) ? r_tap + TAP_W'(1) : '0;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        w_mac   = 1'b0;
        w_post  = 1'b0;
        case (r_state)
            IDLE:  if (w_start) w_next = CLEAR;
            CLEAR: begin w_clear = 1'b1; w_next = MAC; end
            MAC: begin
                w_mac = 1'b1;
                if (r_tap == TAP_W'(KK - 1)) w_next = POST;
            end
            POST:  begin w_post = 1'b1; w_next = IDLE; end
            default: w_next = IDLE;
        endcase
    end

    // Config is frozen while a run is in flight so POST uses the settings it started with.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_relu  <= 1'b0;
            r_bcast <= 1'b0;
            r_shift <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ptr   <= '0;
            r_rdata <= '0;
        end else begin
            if (w_ctrl_wr && !w_busy) begin
                r_relu  <= wdata_i[CTRL_RELU];
                r_bcast <= wdata_i[CTRL_BCAST];
                r_shift <= wdata_i[CTRL_SHIFT_LO +: SHIFT_W];
            end
            if (r_state == POST)
                r_done <= 1'b1;
            else if ((r_state == CLEAR) ||
                     (w_ctrl_wr && (wdata_i[CTRL_START] || wdata_i[CTRL_CLR_DONE])))
                r_done <= 1'b0;
            if (w_stat_wr && wdata_i[STAT_ERR]) r_err <= 1'b0;
            else if (w_err_set)                 r_err <= 1'b1;
            if (w_ptr_wr && !w_busy)       r_ptr <= wdata_i[PTR_W-1:0];
            else if (w_data_wr && !w_busy) r_ptr <= r_ptr + PTR_W'(BPW);
            if (w_rd_en) r_rdata <= w_rd;
        end
    end

    // NOTE: the operand buffer is reset-cleared so an aborted run never leaves stale operands behind.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_buf <= '{default: '0};
        end else if (w_data_wr && !w_busy) begin
            for (int b = 0; b < BPW; b++)
                if (wen_i[b] && w_bok[b])
                    r_buf[w_bidx[b][BUF_AW-1:0]] <= wdata_i[DATA_WIDTH*b +: DATA_WIDTH];
        end
    end

    always_comb begin
        w_rd = '0;
        case (addr_i)
            A_CTRL: begin
                w_rd[CTRL_RELU]                 = r_relu;
                w_rd[CTRL_BCAST]                = r_bcast;
                w_rd[CTRL_SHIFT_LO +: SHIFT_W]  = r_shift;
            end
            A_STATUS: begin
                w_rd[STAT_BUSY] = w_busy;
                w_rd[STAT_DONE] = r_done;
                w_rd[STAT_ERR]  = r_err;
            end
            A_PTR:  w_rd[PTR_W-1:0] = r_ptr;
            A_DATA: w_rd = '0;
            default: begin
                // First lane of each word lands in the most significant byte.
                for (int l = 0; l < N; l++)
                    if (w_res_word == ADDR_W'(l / BPW))
                        w_rd[AXI_WIDTH-1-DATA_WIDTH*(l%BPW) -: DATA_WIDTH] = w_res[l];
            end
        endcase
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [BUF_AW-1:0] w_widx, w_xidx;
        assign w_widx = BUF_AW'(i*KK) + BUF_AW'(r_tap);
        assign w_xidx = (r_bcast ? BUF_AW'(B_BASE) : BUF_AW'(X_BASE + i*KK)) + BUF_AW'(r_tap);

        npu_mac_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .ACC_W     (ACC_W)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_clear(w_clear),
            .i_mac  (w_mac),
            .i_post (w_post),
            .i_w    (r_buf[w_widx]),
            .i_x    (r_buf[w_xidx]),
            .i_shift(r_shift),
            .i_relu (r_relu),
            .o_res  (w_res[i])
        );
    end

    assign rdata_o    = r_rdata;
    assign busy_o     = w_busy;
    assign done_irq_o = r_done;

endmodule

// File: tb/tb_npu_seq_engine.sv
// Directed self-checking bench for npu_seq_engine with hand-computed result words.
module tb_npu_seq_engine;

    localparam int N  = 10;
    localparam int KK = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_i = 1'b0;
    logic [3:0]  wen_i = 4'h0;
    logic [4:0]  addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        busy_o, done_irq_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] img [192];
    logic [31:0] rd;

    always #5 clk = ~clk;

    npu_seq_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .wen_i     (wen_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .rdata_o   (rdata_o),
        .busy_o    (busy_o),
        .done_irq_o(done_irq_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        req_i = 1'b1; wen_i = be; addr_i = a; wdata_i = d;
        @(negedge clk);
        req_i = 1'b0; wen_i = 4'h0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        req_i = 1'b1; wen_i = 4'h0; addr_i = a;
        @(negedge clk);
        req_i = 1'b0;
        d = rdata_o;
    endtask

    task automatic read_check(input logic [4:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic clear_img();
        for (int k = 0; k < 192; k++) img[k] = 8'h00;
    endtask

    task automatic push_img();
        bus_write(5'd2, 32'd0, 4'hF);
        for (int w = 0; w < 48; w++)
            bus_write(5'd3, {img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]},
                      (w == 47) ? 4'b0001 : 4'hF);
    endtask

    task automatic run_check(input logic [31:0] ctrl);
        int cnt;
        bus_write(5'd0, ctrl, 4'hF);
        check("busy_rise", {31'b0, busy_o}, 32'd1);
        check("done_cleared_at_start", {31'b0, done_irq_o}, 32'd0);
        cnt = 0;
        while (busy_o && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("busy_cycles", cnt, 32'd11);
        check("done_set", {31'b0, done_irq_o}, 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_done", {31'b0, done_irq_o}, 32'd0);
        read_check(5'd1, 32'h0, "rst_status");

        // Weights 1, lane i inputs i+1, SHIFT 0: res[i] = 9*(i+1).
        clear_img();
        for (int i = 0; i < N; i++)
            for (int t = 0; t < KK; t++) begin
                img[i*KK + t]     = 8'd1;
                img[(N+i)*KK + t] = 8'(i + 1);
            end
        push_img();
        read_check(5'd2, 32'd192, "ptr_after_load");
        run_check(32'h0000_0001);
        read_check(5'd4, 32'h09121B24, "basic_res0");
        read_check(5'd5, 32'h2D363F48, "basic_res1");
        read_check(5'd6, 32'h515A0000, "basic_res2");
        read_check(5'd7, 32'h00000000, "res_past_lanes");
        read_check(5'd0, 32'h00000000, "ctrl_readback");
        read_check(5'd1, 32'h00000002, "status_done");
        bus_write(5'd0, 32'h0000_0008, 4'hF);
        check("rdata_hold", rdata_o, 32'h00000002);
        check("clr_done", {31'b0, done_irq_o}, 32'd0);

        // Lane 0: 127*127*9, lane 1: -128*127*9.
        clear_img();
        for (int t = 0; t < KK; t++) begin
            img[t]      = 8'd127;
            img[9 + t]  = 8'h80;
            img[90 + t] = 8'd127;
            img[99 + t] = 8'd127;
        end
        push_img();
        run_check(32'h0000_0C01);
        read_check(5'd4, 32'h23DC0000, "shift12_norelu");
        run_check(32'h0000_0C03);
        read_check(5'd4, 32'h23000000, "shift12_relu");
        read_check(5'd0, 32'h00000C02, "ctrl_cfg_read");
        run_check(32'h0000_0001);
        read_check(5'd4, 32'h7F800000, "saturate");

        // Broadcast inputs 2, lane i weights i: 18*i saturated to 127.
        clear_img();
        for (int i = 0; i < N; i++)
            for (int t = 0; t < KK; t++) img[i*KK + t] = 8'(i);
        for (int t = 0; t < KK; t++) img[180 + t] = 8'd2;
        push_img();
        run_check(32'h0000_0005);
        read_check(5'd4, 32'h00122436, "bcast_res0");
        read_check(5'd5, 32'h485A6C7E, "bcast_res1");
        read_check(5'd6, 32'h7F7F0000, "bcast_res2");

        // Accesses during a run are ignored and flag err.
        bus_write(5'd2, 32'd180, 4'hF);
        bus_write(5'd0, 32'h0000_0005, 4'hF);
        bus_write(5'd2, 32'd0, 4'hF);
        bus_write(5'd3, 32'h05050505, 4'hF);
        bus_write(5'd0, 32'h0000_0001, 4'hF);
        begin
            int cnt;
            cnt = 0;
            while (busy_o && cnt < 100) begin
                cnt++;
                @(negedge clk);
            end
            check("busy_err_run_idle", {31'b0, busy_o}, 32'd0);
        end
        read_check(5'd4, 32'h00122436, "busy_ignore_res0");
        read_check(5'd5, 32'h485A6C7E, "busy_ignore_res1");
        read_check(5'd1, 32'h00000006, "busy_err_status");
        read_check(5'd2, 32'd180, "busy_ptr_kept");
        bus_write(5'd1, 32'h0000_0004, 4'hF);
        read_check(5'd1, 32'h00000002, "err_cleared");

        // Partial byte enables: only bytes 0,1 land, pointer still moves by 4.
        bus_write(5'd2, 32'd0, 4'hF);
        bus_write(5'd3, 32'hAABBCCDD, 4'b0011);
        read_check(5'd2, 32'd4, "ptr_adv_partial");
        run_check(32'h0000_0205);
        read_check(5'd4, 32'hD404090D, "partial_bytes_res0");

        // Write straddling the end of the buffer.
        bus_write(5'd2, 32'd188, 4'hF);
        bus_write(5'd3, 32'h00000002, 4'hF);
        read_check(5'd1, 32'h00000006, "oor_err");
        bus_write(5'd1, 32'h0000_0004, 4'hF);

        // Abort during MAC tap 4.
        bus_write(5'd0, 32'h0000_0005, 4'hF);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy_o}, 32'd0);
        check("abort_done", {31'b0, done_irq_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        read_check(5'd4, 32'h00000000, "abort_res0");
        read_check(5'd1, 32'h00000000, "abort_status");

        push_img();
        run_check(32'h0000_0005);
        read_check(5'd4, 32'h00122436, "rerun_res0");
        read_check(5'd6, 32'h7F7F0000, "rerun_res2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
